// File: rtl/entry_bcd_packer.sv
// Keypad code-entry collector: builds the masked bcdPac_t display packet, the raw code
// and the update/code/timeout strobes for up to six BCD digits.
module entry_bcd_packer #(
    parameter int unsigned MASK_DELAY     = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        backspace,
    input  logic        clear,
    input  logic        mask_en,
    output logic [23:0] bcd_packet,
    output logic        pkt_update,
    output logic [2:0]  digit_count,
    output logic        full,
    output logic [23:0] code_out,
    output logic        code_valid,
    output logic        timeout
);

    localparam int MASK_W = $clog2(MASK_DELAY + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [MASK_W-1:0] MASK_LOAD = MASK_W'(MASK_DELAY);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [23:0]         raw_r, raw_s;
    logic [2:0]          count_r, count_s;
    logic [MASK_W-1:0]   mask_r, mask_s;
    logic [TMO_W-1:0]    tmo_r, tmo_s;
    logic                code_valid_s, timeout_s;
    logic [23:0]         pkt_s, code_s;
    logic [23:0]         bcd_packet_r, code_out_r;
    logic                pkt_update_r, full_r, code_valid_r, timeout_r;

    // Field i shows blank beyond the count; when masking, only a fresh newest digit stays raw.
    function automatic logic [23:0] map_packet(input logic [23:0] raw, input logic [2:0] cnt,
                                               input logic mask_live, input logic men);
        logic [23:0] pkt;
        pkt = 24'h000000;
        for (int i = 0; i < 6; i++) begin
            if (i >= int'(cnt)) begin
                pkt[i*4 +: 4] = 4'hB;
            end else if (!men || (i == 0 && mask_live)) begin
                pkt[i*4 +: 4] = raw[i*4 +: 4];
            end else begin
                pkt[i*4 +: 4] = 4'hA;
            end
        end
        return pkt;
    endfunction

    function automatic logic [23:0] map_code(input logic [23:0] raw, input logic [2:0] cnt);
        logic [23:0] code;
        code = 24'h000000;
        for (int i = 0; i < 6; i++) begin
            if (i < int'(cnt)) begin
                code[i*4 +: 4] = raw[i*4 +: 4];
            end else begin
                code[i*4 +: 4] = 4'h0;
            end
        end
        return code;
    endfunction

    // Next-state: one event per cycle, clear > backspace > digit, then inactivity timing.
    always_comb begin
        state_s      = state_r;
        raw_s        = raw_r;
        count_s      = count_r;
        tmo_s        = tmo_r;
        code_valid_s = 1'b0;
        timeout_s    = 1'b0;
        if (mask_r != {MASK_W{1'b0}}) begin
            mask_s = mask_r - MASK_W'(1);
        end else begin
            mask_s = {MASK_W{1'b0}};
        end

        if (clear) begin
            state_s = ST_IDLE;
            raw_s   = 24'h000000;
            count_s = 3'd0;
            mask_s  = {MASK_W{1'b0}};
            tmo_s   = {TMO_W{1'b0}};
        end else if (backspace) begin
            if (state_r != ST_IDLE) begin
                raw_s   = {4'h0, raw_r[23:4]};
                count_s = count_r - 3'd1;
                mask_s  = {MASK_W{1'b0}};
                tmo_s   = {TMO_W{1'b0}};
                if (count_r == 3'd1) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ENTRY;
                end
            end else begin
                tmo_s = {TMO_W{1'b0}};
            end
        end else if (digit_valid && (digit <= 4'd9) && (state_r != ST_FULL)) begin
            raw_s   = {raw_r[19:0], digit};
            count_s = count_r + 3'd1;
            mask_s  = MASK_LOAD;
            tmo_s   = {TMO_W{1'b0}};
            if (count_r == 3'd5) begin
                state_s      = ST_FULL;
                code_valid_s = 1'b1;
            end else begin
                state_s = ST_ENTRY;
            end
        end else if (state_r != ST_IDLE) begin
            if (tmo_r == TMO_LAST) begin
                state_s   = ST_IDLE;
                raw_s     = 24'h000000;
                count_s   = 3'd0;
                mask_s    = {MASK_W{1'b0}};
                tmo_s     = {TMO_W{1'b0}};
                timeout_s = 1'b1;
            end else begin
                tmo_s = tmo_r + TMO_W'(1);
            end
        end else begin
            tmo_s = {TMO_W{1'b0}};
        end
    end

    assign pkt_s  = map_packet(raw_s, count_s, (mask_s != {MASK_W{1'b0}}), mask_en);
    assign code_s = map_code(raw_s, count_s);

    // State and registered outputs; packet compared against its old value for the update strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            raw_r        <= 24'h000000;
            count_r      <= 3'd0;
            mask_r       <= {MASK_W{1'b0}};
            tmo_r        <= {TMO_W{1'b0}};
            bcd_packet_r <= 24'hBBBBBB;
            code_out_r   <= 24'h000000;
            pkt_update_r <= 1'b0;
            full_r       <= 1'b0;
            code_valid_r <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            raw_r        <= raw_s;
            count_r      <= count_s;
            mask_r       <= mask_s;
            tmo_r        <= tmo_s;
            bcd_packet_r <= pkt_s;
            code_out_r   <= code_s;
            pkt_update_r <= (pkt_s != bcd_packet_r);
            full_r       <= (state_s == ST_FULL);
            code_valid_r <= code_valid_s;
            timeout_r    <= timeout_s;
        end
    end

    assign bcd_packet  = bcd_packet_r;
    assign pkt_update  = pkt_update_r;
    assign digit_count = count_r;
    assign full        = full_r;
    assign code_out    = code_out_r;
    assign code_valid  = code_valid_r;
    assign timeout     = timeout_r;

endmodule
